// File: rtl/boot_pkg.sv
// Shared types and constants for the flash boot loader.
// State encoding, SPI read command and bits-per-byte.
package boot_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_ACK,
    ST_GAP,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam logic [7:0] SPI_READ_CMD  = 8'h03;
  localparam int         BITS_PER_BYTE = 8;
endpackage

// File: rtl/flash_boot_loader_if.sv
// SPI-master request/response and RAM write-port bundle.
// master: the boot loader side; slave: SPI master + RAM side.
interface flash_boot_loader_if #(
  parameter int MEM_AW = 13
);
  logic              spi_en;
  logic [23:0]       spi_addr;
  logic              spi_read_req;
  logic [7:0]        spi_wr_data;
  logic [17:0]       spi_words_to_read;
  logic              spi_valid;
  logic [7:0]        spi_rd_data;
  logic              spi_end_transaction;
  logic              spi_rd_ack;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output spi_en, spi_addr, spi_read_req,
    output spi_wr_data, spi_words_to_read,
    output spi_rd_ack,
    input  spi_valid, spi_rd_data,
    input  spi_end_transaction,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  spi_en, spi_addr, spi_read_req,
    input  spi_wr_data, spi_words_to_read,
    input  spi_rd_ack,
    output spi_valid, spi_rd_data,
    output spi_end_transaction,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/byte_to_word_packer.sv
// Packs a byte stream into little-endian 32-bit RAM writes.
// Ports: clr/byte_valid/byte_data/flush in; lane, we/addr/wdata out.
module byte_to_word_packer #(
  parameter int MEM_AW = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              flush,
  output logic [1:0]        lane,
  output logic              we,
  output logic [MEM_AW-1:0] addr,
  output logic [31:0]       wdata
);
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       word_q, word_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  always_comb begin
    lane_d  = lane_q;
    word_d  = word_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (clr) begin
      lane_d = '0;
      word_d = '0;
      idx_d  = '0;
    end else if (byte_valid) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_data;
      lane_d = lane_q + 2'd1;
      if (lane_q == 2'd3) begin
        we_d    = 1'b1;
        addr_d  = idx_q;
        wdata_d = word_d;
        word_d  = '0;
        idx_d   = idx_q + 1'b1;
      end
    end else if (flush) begin
      // word_q upper lanes are already zero
      we_d    = 1'b1;
      addr_d  = idx_q;
      wdata_d = word_q;
      word_d  = '0;
      lane_d  = '0;
      idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      lane_q  <= lane_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign lane  = lane_q;
  assign we    = we_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
endmodule

// File: rtl/flash_boot_loader.sv
// Copies a fixed image from SPI flash into RAM, holding the CPU in reset.
// Ports: clk, reset, start, busy, done, cpu_rst, bus (SPI + RAM).
module flash_boot_loader
  import boot_pkg::*;
#(
  parameter logic [23:0] FLASH_BASE  = 24'h100000,
  parameter logic [31:0] IMAGE_BYTES = 32'd8192,
  parameter int          CHUNK_BYTES = 4096,
  parameter int          MEM_AW      = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic cpu_rst,
  flash_boot_loader_if.master bus
);
  localparam logic [31:0] CHUNK_W = 32'(CHUNK_BYTES);
  localparam logic [17:0] BPB     = 18'(BITS_PER_BYTE);

  state_e      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [23:0] ptr_q, ptr_d;
  logic [23:0] addr_q, addr_d;
  logic [17:0] bits_q, bits_d;
  logic        done_q, done_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic [14:0] len_c;
  logic        pk_clr, pk_valid, pk_flush;
  logic [1:0]  pk_lane;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    bits_d    = bits_q;
    done_d    = done_q;
    cpu_rst_d = cpu_rst_q;
    len_c     = '0;
    pk_clr    = 1'b0;
    pk_valid  = 1'b0;
    pk_flush  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d = 1'b0;
          if (IMAGE_BYTES == 32'd0) begin
            state_d = ST_DONE;
          end else begin
            rem_d   = IMAGE_BYTES;
            ptr_d   = FLASH_BASE;
            pk_clr  = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: state_d = ST_RECV;
      ST_RECV: begin
        if (bus.spi_valid) begin
          pk_valid = 1'b1;
          rem_d    = rem_q - 32'd1;
          ptr_d    = ptr_q + 24'd1;
        end
        if (bus.spi_end_transaction) state_d = ST_ACK;
      end
      ST_ACK: state_d = ST_GAP;
      ST_GAP: begin
        if (rem_q != 32'd0)       state_d = ST_REQ;
        else if (pk_lane != 2'd0) state_d = ST_FLUSH;
        else                      state_d = ST_DONE;
      end
      ST_FLUSH: begin
        pk_flush = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Chunk request is latched on entry so it is valid with spi_en
    if (state_d == ST_REQ) begin
      len_c  = (rem_d < CHUNK_W) ? rem_d[14:0] : CHUNK_W[14:0];
      addr_d = ptr_d;
      bits_d = 18'(len_c) * BPB;
    end
    if (state_d == ST_DONE) begin
      done_d    = 1'b1;
      cpu_rst_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      bits_q    <= '0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      bits_q    <= bits_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  byte_to_word_packer #(.MEM_AW(MEM_AW)) u_pack (
    .clk        (clk),
    .reset      (reset),
    .clr        (pk_clr),
    .byte_valid (pk_valid),
    .byte_data  (bus.spi_rd_data),
    .flush      (pk_flush),
    .lane       (pk_lane),
    .we         (bus.mem_we),
    .addr       (bus.mem_addr),
    .wdata      (bus.mem_wdata)
  );

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done    = done_q;
  assign cpu_rst = cpu_rst_q;

  assign bus.spi_en            = (state_q == ST_REQ);
  assign bus.spi_rd_ack        = (state_q == ST_ACK);
  assign bus.spi_addr          = addr_q;
  assign bus.spi_words_to_read = bits_q;
  assign bus.spi_read_req      = 1'b1;
  assign bus.spi_wr_data       = 8'h00;
endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench: four loader instances with different image/chunk sizes,
// flash responder per instance, reference model and literal checks.
module tb_flash_boot_loader;
  localparam int N      = 4;
  localparam int MEM_AW = 13;

  logic clk;
  logic reset;
  logic [N-1:0] start, busy, done, cpu_rst;
  int checks = 0;
  int errors = 0;

  function automatic int img_of(input int i);
    case (i)
      0: return 8;
      1: return 10;
      2: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int chk_of(input int i);
    case (i)
      0: return 4096;
      1: return 4;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  // flash content: byte at 0x100000+k is k+1
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    logic [23:0] d;
    d = a - 24'h100000 + 24'd1;
    return d[7:0];
  endfunction

  function automatic int ntx(input int img, input int chk);
    return (img + chk - 1) / chk;
  endfunction

  function automatic int nwr(input int img);
    return (img + 3) / 4;
  endfunction

  function automatic logic [23:0] exp_addr(input int chk, input int k);
    return 24'h100000 + 24'(k * chk);
  endfunction

  function automatic int exp_bits(input int img, input int chk, input int k);
    int rem;
    rem = img - k * chk;
    return 8 * ((rem < chk) ? rem : chk);
  endfunction

  function automatic logic [31:0] exp_word(input int img, input int w);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      if (4 * w + j < img)
        r[8*j +: 8] = fbyte(24'h100000 + 24'(4 * w + j));
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_i
    localparam int IMG = img_of(g);
    localparam int CHK = chk_of(g);

    flash_boot_loader_if #(.MEM_AW(MEM_AW)) bus ();

    flash_boot_loader #(
      .FLASH_BASE  (24'h100000),
      .IMAGE_BYTES (32'(IMG)),
      .CHUNK_BYTES (CHK),
      .MEM_AW      (MEM_AW)
    ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .cpu_rst (cpu_rst[g]),
      .bus     (bus)
    );

    int tx_i  = 0;
    int wr_i  = 0;
    int n_ack = 0;
    logic [31:0] cap_mem [16];
    logic [23:0] cap_addr [8];
    int          cap_bits [8];

    // SPI master stand-in; strays a byte strobe whenever idle
    initial begin
      int phase;
      int left;
      logic [23:0] p;
      phase = 0;
      left  = 0;
      p     = '0;
      bus.spi_valid           = 1'b0;
      bus.spi_rd_data         = 8'h00;
      bus.spi_end_transaction = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        bus.spi_valid = 1'b0;
        if (reset !== 1'b0) begin
          phase = 0;
          bus.spi_end_transaction = 1'b0;
        end else begin
          case (phase)
            0: begin
              if (bus.spi_en === 1'b1) begin
                p     = bus.spi_addr;
                left  = int'(bus.spi_words_to_read) / 8;
                phase = 1;
              end else begin
                bus.spi_valid   = 1'b1;
                bus.spi_rd_data = 8'hEE;
              end
            end
            1: begin
              if (left > 0) begin
                bus.spi_valid   = 1'b1;
                bus.spi_rd_data = fbyte(p);
                p    = p + 24'd1;
                left = left - 1;
              end else begin
                bus.spi_end_transaction = 1'b1;
                phase = 2;
              end
            end
            default: begin
              if (bus.spi_rd_ack === 1'b1) begin
                bus.spi_end_transaction = 1'b0;
                phase = 0;
              end
            end
          endcase
        end
      end
    end

    always @(negedge clk) begin
      if (reset === 1'b0) begin
        if (bus.spi_en !== 1'b0) begin
          chk($sformatf("g%0d_en_extra", g), 64'(tx_i < ntx(IMG, CHK)), 64'd1);
          chk($sformatf("g%0d_spi_addr", g), 64'(bus.spi_addr),
              64'(exp_addr(CHK, tx_i)));
          chk($sformatf("g%0d_spi_bits", g), 64'(bus.spi_words_to_read),
              64'(exp_bits(IMG, CHK, tx_i)));
          chk($sformatf("g%0d_spi_const", g),
              64'({bus.spi_read_req, bus.spi_wr_data}), 64'h100);
          if (tx_i < 8) begin
            cap_addr[tx_i] = bus.spi_addr;
            cap_bits[tx_i] = int'(bus.spi_words_to_read);
          end
          tx_i++;
        end
        if (bus.mem_we !== 1'b0) begin
          chk($sformatf("g%0d_we_extra", g), 64'(wr_i < nwr(IMG)), 64'd1);
          chk($sformatf("g%0d_mem_addr", g), 64'(bus.mem_addr),
              64'(wr_i % (1 << MEM_AW)));
          chk($sformatf("g%0d_mem_wdata", g), 64'(bus.mem_wdata),
              64'(exp_word(IMG, wr_i)));
          cap_mem[bus.mem_addr[3:0]] = bus.mem_wdata;
          wr_i++;
        end
        if (bus.spi_rd_ack === 1'b1) n_ack++;
      end
    end
  end

  task automatic pulse_start(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input string name);
    int n;
    n = 0;
    while (done[g] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(done[g]), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'hF);
    chk("rst_spi_en", 64'(g_i[0].bus.spi_en), 64'd0);
    chk("rst_ack", 64'(g_i[0].bus.spi_rd_ack), 64'd0);
    chk("rst_we", 64'(g_i[0].bus.mem_we), 64'd0);
    chk("rst_spi_addr", 64'(g_i[0].bus.spi_addr), 64'd0);
    chk("rst_bits", 64'(g_i[0].bus.spi_words_to_read), 64'd0);
    chk("rst_mem_addr", 64'(g_i[0].bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(g_i[0].bus.mem_wdata), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 8-byte image, single chunk
    pulse_start(0);
    chk("t1_busy", 64'(busy[0]), 64'd1);
    chk("t1_cpu_rst_hold", 64'(cpu_rst[0]), 64'd1);
    wait_done(0, "t1_done");
    chk("t1_cpu_rst", 64'(cpu_rst[0]), 64'd0);
    chk("t1_busy_end", 64'(busy[0]), 64'd0);
    repeat (5) @(negedge clk);
    chk("t1_done_held", 64'(done[0]), 64'd1);
    chk("t1_n_en", 64'(g_i[0].tx_i), 64'd1);
    chk("t1_n_we", 64'(g_i[0].wr_i), 64'd2);
    chk("t1_n_ack", 64'(g_i[0].n_ack), 64'd1);
    chk("t1_addr0", 64'(g_i[0].cap_addr[0]), 64'h100000);
    chk("t1_bits0", 64'(g_i[0].cap_bits[0]), 64'd64);
    chk("t1_mem0", 64'(g_i[0].cap_mem[0]), 64'h04030201);
    chk("t1_mem1", 64'(g_i[0].cap_mem[1]), 64'h08070605);

    // 10 bytes in 4-byte chunks, flush of the tail
    pulse_start(1);
    wait_done(1, "t2_done");
    repeat (3) @(negedge clk);
    chk("t2_n_en", 64'(g_i[1].tx_i), 64'd3);
    chk("t2_n_we", 64'(g_i[1].wr_i), 64'd3);
    chk("t2_n_ack", 64'(g_i[1].n_ack), 64'd3);
    chk("t2_addr1", 64'(g_i[1].cap_addr[1]), 64'h100004);
    chk("t2_addr2", 64'(g_i[1].cap_addr[2]), 64'h100008);
    chk("t2_bits0", 64'(g_i[1].cap_bits[0]), 64'd32);
    chk("t2_bits2", 64'(g_i[1].cap_bits[2]), 64'd16);
    chk("t2_mem2", 64'(g_i[1].cap_mem[2]), 64'h00000A09);

    // 6 bytes in 3-byte chunks, word spans a chunk boundary
    pulse_start(2);
    wait_done(2, "t3_done");
    repeat (3) @(negedge clk);
    chk("t3_n_ack", 64'(g_i[2].n_ack), 64'd2);
    chk("t3_mem0", 64'(g_i[2].cap_mem[0]), 64'h04030201);
    chk("t3_mem1", 64'(g_i[2].cap_mem[1]), 64'h00000605);

    // empty image
    pulse_start(3);
    chk("t4_done_next", 64'(done[3]), 64'd1);
    chk("t4_cpu_rst", 64'(cpu_rst[3]), 64'd0);
    repeat (5) @(negedge clk);
    chk("t4_no_en", 64'(g_i[3].tx_i), 64'd0);
    chk("t4_no_we", 64'(g_i[3].wr_i), 64'd0);

    // re-run with a start while busy
    g_i[0].tx_i  = 0;
    g_i[0].wr_i  = 0;
    g_i[0].n_ack = 0;
    pulse_start(0);
    chk("t5_done_clr", 64'(done[0]), 64'd0);
    repeat (2) @(negedge clk);
    pulse_start(0);
    chk("t5_busy", 64'(busy[0]), 64'd1);
    wait_done(0, "t5_done");
    repeat (20) @(negedge clk);
    chk("t5_n_en", 64'(g_i[0].tx_i), 64'd1);
    chk("t5_n_we", 64'(g_i[0].wr_i), 64'd2);

    // reset in the middle of chunk 2, then restart
    g_i[1].tx_i  = 0;
    g_i[1].wr_i  = 0;
    g_i[1].n_ack = 0;
    pulse_start(1);
    begin
      int n;
      n = 0;
      while (g_i[1].tx_i < 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("t6_second_chunk", 64'(g_i[1].tx_i), 64'd2);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_busy", 64'(busy[1]), 64'd0);
    chk("t6_done", 64'(done[1]), 64'd0);
    chk("t6_cpu_rst", 64'(cpu_rst[1]), 64'd1);
    chk("t6_we", 64'(g_i[1].bus.mem_we), 64'd0);
    chk("t6_wr_count", 64'(g_i[1].wr_i), 64'd1);
    g_i[1].tx_i  = 0;
    g_i[1].wr_i  = 0;
    g_i[1].n_ack = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start(1);
    wait_done(1, "t6_done_again");
    repeat (3) @(negedge clk);
    chk("t6_n_en", 64'(g_i[1].tx_i), 64'd3);
    chk("t6_addr0", 64'(g_i[1].cap_addr[0]), 64'h100000);
    chk("t6_mem0", 64'(g_i[1].cap_mem[0]), 64'h04030201);
    chk("t6_mem2", 64'(g_i[1].cap_mem[2]), 64'h00000A09);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
